scarv_cop_issue: RTL

CPU-side initiator for the coprocessor instruction interface. It accepts 32-bit encoded XCrypto instructions and the rs1 value from the host pipeline, drives them to the coprocessor over the request channel, and collects in-order responses (status code and optional GPR writeback) from the response channel. It tracks outstanding instructions, applies backpressure in both directions and returns each response to the host writeback stage through a registered valid/ready port.

---
 rtl/scarv_cop_issue_if.sv | 38 +++
 rtl/scarv_cop_issue.sv | 136 +++++++++++++
 2 files changed

// File: rtl/scarv_cop_issue_if.sv
// Host/coprocessor handshake bundle for scarv_cop_issue.
// The master modport belongs to the issue block; the slave modport is the environment (host pipeline plus coprocessor).
interface scarv_cop_issue_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [31:0] issue_rs1;
  logic        cpu_insn_req;
  logic        cop_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        cop_insn_rsp;
  logic        cpu_insn_ack;
  logic [2:0]  cop_insn_result;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_result;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  modport master (
    input  issue_valid, issue_instr, issue_rs1, cop_insn_ack, cop_insn_rsp,
           cop_insn_result, cop_wen, cop_waddr, cop_wdata, wb_ready,
    output issue_ready, cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
           wb_valid, wb_result, wb_wen, wb_waddr, wb_wdata
  );

  modport slave (
    output issue_valid, issue_instr, issue_rs1, cop_insn_ack, cop_insn_rsp,
           cop_insn_result, cop_wen, cop_waddr, cop_wdata, wb_ready,
    input  issue_ready, cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
           wb_valid, wb_result, wb_wen, wb_waddr, wb_wdata
  );
endinterface

// File: rtl/scarv_cop_issue.sv
// CPU-side coprocessor issue/response initiator with in-order outstanding tracking.
// Define SCARV_COP_ISSUE_TIMEOUT_EN to add a watchdog that injects status-7 responses.
module scarv_cop_issue #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic               g_clk,
  input  logic               g_rst,
  scarv_cop_issue_if.master  bus,
  output logic [3:0]         outstanding,
  output logic               err_unexpected
);

  typedef struct packed {
    logic [2:0]  result;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rsp_t;

  generate
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || TIMEOUT < 1) begin : g_bad_cfg
      $error("scarv_cop_issue: parameter out of range");
    end
  endgenerate

  logic        req_q, req_d;
  logic [31:0] enc_q, enc_d;
  logic [31:0] rs1_q, rs1_d;
  logic [3:0]  out_q, out_d;
  logic        wbv_q, wbv_d;
  rsp_t        wb_q, wb_d;
  logic        err_q, err_d;

  logic [4:0]  inflight;
  logic        issue_acc, req_ack, rsp_free, rsp_take, rsp_bad, to_fire;

  // The holding-register entry counts toward the in-flight limit.
  assign inflight        = {1'b0, out_q} + {4'd0, req_q};
  assign bus.issue_ready = (!req_q || bus.cop_insn_ack) && (inflight < 5'(MAX_OUTSTANDING));
  assign issue_acc       = bus.issue_valid && bus.issue_ready;
  assign req_ack         = req_q && bus.cop_insn_ack;

  assign rsp_free = !wbv_q || bus.wb_ready;
  assign rsp_take = bus.cop_insn_rsp && rsp_free && (out_q != 4'd0);
  assign rsp_bad  = bus.cop_insn_rsp && rsp_free && (out_q == 4'd0);

`ifdef SCARV_COP_ISSUE_TIMEOUT_EN
  localparam logic [31:0] WD_LIM = 32'(TIMEOUT - 1);
  logic [31:0] wdog_q, wdog_d;

  // A real response in the same cycle wins; the counter saturates so injection just waits.
  assign to_fire = (wdog_q == WD_LIM) && (out_q != 4'd0) && rsp_free && !bus.cop_insn_rsp;

  always_comb begin
    wdog_d = wdog_q;
    if (out_q == 4'd0 || rsp_take || to_fire) wdog_d = '0;
    else if (wdog_q != WD_LIM)                wdog_d = wdog_q + 32'd1;
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    req_d = req_q;
    enc_d = enc_q;
    rs1_d = rs1_q;
    if (issue_acc) begin
      req_d = 1'b1;
      enc_d = bus.issue_instr;
      rs1_d = bus.issue_rs1;
    end else if (req_ack) begin
      req_d = 1'b0;
    end

    out_d = out_q;
    case ({req_ack, rsp_take || to_fire})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    wbv_d = wbv_q;
    wb_d  = wb_q;
    if (rsp_take) begin
      wbv_d = 1'b1;
      wb_d  = '{result: bus.cop_insn_result, wen: bus.cop_wen,
                waddr: bus.cop_waddr, wdata: bus.cop_wdata};
    end else if (to_fire) begin
      wbv_d = 1'b1;
      wb_d  = '{result: 3'd7, wen: 1'b0, waddr: 5'd0, wdata: 32'd0};
    end else if (bus.wb_ready) begin
      wbv_d = 1'b0;
    end

    err_d = err_q || rsp_bad;
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      req_q <= 1'b0;
      enc_q <= '0;
      rs1_q <= '0;
      out_q <= '0;
      wbv_q <= 1'b0;
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      req_q <= req_d;
      enc_q <= enc_d;
      rs1_q <= rs1_d;
      out_q <= out_d;
      wbv_q <= wbv_d;
      wb_q  <= wb_d;
      err_q <= err_d;
    end
  end

  assign bus.cpu_insn_req = req_q;
  assign bus.cpu_insn_enc = enc_q;
  assign bus.cpu_rs1      = rs1_q;
  assign bus.cpu_insn_ack = rsp_free;
  assign bus.wb_valid     = wbv_q;
  assign bus.wb_result    = wb_q.result;
  assign bus.wb_wen       = wb_q.wen;
  assign bus.wb_waddr     = wb_q.waddr;
  assign bus.wb_wdata     = wb_q.wdata;
  assign outstanding      = out_q;
  assign err_unexpected   = err_q;

endmodule
